rr_client_requester: RTL and testbench

//  Client-side agent for the two-port round-robin arbiter: queues local jobs, drives one

---
 rtl/rr_client_requester.sv | 155 +++++++++++++++
 tb/tb_rr_client_requester.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_client_requester.sv
// Client agent for a two-port round-robin arbiter: queues jobs, drives one request
// line and counts granted beats per job. Optional watchdog: RR_CLIENT_WATCHDOG_EN.
module rr_client_requester #(
  parameter  int DEPTH    = 4,
  parameter  int LEN_W    = 4,
  parameter  int MAX_WAIT = 8,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             job_valid_i,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             job_ready_o,
  output logic             req_o,
  input  logic             ack_i,
  output logic             beat_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] level_o,
  output logic             starve_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP1, GAP2} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;
  logic             beat, done;

  // ---------------- job FIFO ----------------
  assign full  = (cnt_q == LVL_W'(DEPTH));
  assign empty = (cnt_q == '0);
  // Full blocks a push even when a pop frees a slot on the same edge.
  assign push  = job_valid_i & ~full;
  assign cnt_d = cnt_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= job_len_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // ---------------- request FSM ----------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    beat    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          rem_d   = mem_q[rd_ptr_q];
          state_d = REQ;
        end
      end
      REQ: begin
        beat = ack_i;
        if (ack_i) begin
          if (rem_q == '0) begin
            done    = 1'b1;
            state_d = GAP1;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      // Two-cycle release gap lets a lagging grant for the old request drain out.
      GAP1: state_d = GAP2;
      GAP2: begin
        if (!empty) begin
          pop     = 1'b1;
          rem_d   = mem_q[rd_ptr_q];
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_o       = (state_q == REQ);
  assign beat_o      = beat;
  assign done_o      = done;
  assign job_ready_o = ~full;
  assign level_o     = cnt_q;
  assign busy_o      = (state_q != IDLE) | ~empty;

  // ---------------- optional starvation watchdog ----------------
`ifdef RR_CLIENT_WATCHDOG_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if (beat || state_q != REQ) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    // Flag is sticky past leaving REQ; only a granted beat proves progress.
    if (beat) begin
      starve_d = 1'b0;
    end else if (state_q == REQ && wait_d == WAIT_W'(MAX_WAIT)) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;
`else
  assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_client_requester.sv
// Directed bench for rr_client_requester; a scoreboard queue holds expected job
// lengths and is checked against beats counted at each done.
module tb_rr_client_requester;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef RR_CLIENT_WATCHDOG_EN
  localparam int WD = 1;
`else
  localparam int WD = 0;
`endif

  logic             clock = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready, req, ack, beat, done, busy, starve;
  logic [LVL_W-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int beat_cnt = 0;
  int done_cnt = 0;

  rr_client_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .MAX_WAIT(8)) dut (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .job_valid_i(job_valid),
    .job_len_i  (job_len),
    .job_ready_o(job_ready),
    .req_o      (req),
    .ack_i      (ack),
    .beat_o     (beat),
    .done_o     (done),
    .busy_o     (busy),
    .level_o    (level),
    .starve_o   (starve)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    ack = 1'b1;
    for (int i = 0; i < 200 && busy; i++) step();
    chk(tag, int'(busy), 0);
    ack = 1'b0;
  endtask

  // Scoreboard: each done pops one expected length and checks the beat count.
  always @(negedge clock) begin
    if (reset_n) begin
      if (beat) beat_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_needs_beat", int'(beat), 1);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          chk("sb_beats", beat_cnt, exp_q.pop_front() + 1);
        end
        beat_cnt = 0;
      end
    end
  end

  logic [4:0] pat;
  int l4[6];

  initial begin
    reset_n = 1'b0; job_valid = 1'b0; job_len = '0; ack = 1'b0;
    pat = 5'b10101;
    l4  = '{0, 1, 2, 0, 1, 3};
    repeat (2) step();
    reset_n = 1'b1;
    step(); step();

    // 1: reset while idle
    #2; reset_n = 1'b0; #1;
    chk("t1_req", int'(req), 0);
    chk("t1_beat", int'(beat), 0);
    chk("t1_done", int'(done), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_level", int'(level), 0);
    chk("t1_ready", int'(job_ready), 1);
    chk("t1_starve", int'(starve), 0);
    step(); reset_n = 1'b1;

    // 2: single 3-beat job with continuous ack
    job_valid = 1'b1; job_len = 4'd2; exp_q.push_back(2);
    step(); job_valid = 1'b0; #2;
    chk("t2_level1", int'(level), 1);
    chk("t2_req_lo", int'(req), 0);
    chk("t2_busy", int'(busy), 1);
    step(); #2;
    chk("t2_req_hi", int'(req), 1);
    chk("t2_level0", int'(level), 0);
    step(); ack = 1'b1; #2;
    chk("t2_beat1", int'(beat), 1); chk("t2_done1", int'(done), 0);
    step(); #2;
    chk("t2_beat2", int'(beat), 1); chk("t2_done2", int'(done), 0);
    step(); #2;
    chk("t2_beat3", int'(beat), 1); chk("t2_done3", int'(done), 1);
    step(); #2;
    chk("t2_gap1_req", int'(req), 0); chk("t2_gap1_beat", int'(beat), 0);
    step(); #2;
    chk("t2_gap2_req", int'(req), 0); chk("t2_gap2_beat", int'(beat), 0);
    ack = 1'b0;
    step(); #2;
    chk("t2_idle_busy", int'(busy), 0);
    chk("t2_idle_req", int'(req), 0);
    chk("t2_dones", done_cnt, 1);

    // 3: toggling ack holds req and beats only on ack
    step();
    job_valid = 1'b1; job_len = 4'd2; exp_q.push_back(2);
    step(); job_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      ack = pat[i]; #2;
      chk("t3_req", int'(req), 1);
      chk("t3_beat", int'(beat), int'(pat[i]));
      chk("t3_done", int'(done), (i == 4) ? 1 : 0);
      step();
    end
    ack = 1'b0;
    step(); step(); #2;
    chk("t3_busy", int'(busy), 0);
    chk("t3_dones", done_cnt, 2);

    // 4: fill FIFO behind a stalled job, sixth job waits for space
    step();
    for (int i = 0; i < 5; i++) begin
      job_valid = 1'b1; job_len = LEN_W'(l4[i]); exp_q.push_back(l4[i]);
      step();
    end
    job_valid = 1'b1; job_len = LEN_W'(l4[5]); exp_q.push_back(l4[5]); #2;
    chk("t4_level_full", int'(level), 4);
    chk("t4_ready_lo", int'(job_ready), 0);
    chk("t4_req", int'(req), 1);
    step(); #2;
    chk("t4_stall_level", int'(level), 4);
    ack = 1'b1; #1;
    chk("t4_done_j1", int'(done), 1);
    step(); ack = 1'b0; #2;
    chk("t4_gap1_level", int'(level), 4);
    chk("t4_gap1_ready", int'(job_ready), 0);
    step(); #2;
    chk("t4_gap2_level", int'(level), 4);
    step(); #2;
    chk("t4_pop_level", int'(level), 3);
    chk("t4_pop_ready", int'(job_ready), 1);
    step(); job_valid = 1'b0; #2;
    chk("t4_push6_level", int'(level), 4);
    drain("t4_drain");
    chk("t4_dones", done_cnt, 8);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: reset mid-burst discards the job and the queue
    step();
    job_valid = 1'b1; job_len = 4'd3; exp_q.push_back(3);
    step(); job_valid = 1'b0;
    step();
    ack = 1'b1; job_valid = 1'b1; job_len = 4'd1; exp_q.push_back(1); #2;
    chk("t5_beat", int'(beat), 1);
    step(); ack = 1'b0; job_valid = 1'b0; #1;
    chk("t5_level_pre", int'(level), 1);
    reset_n = 1'b0; #1;
    chk("t5_req", int'(req), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_level", int'(level), 0);
    chk("t5_busy", int'(busy), 0);
    exp_q.delete(); beat_cnt = 0;
    step(); reset_n = 1'b1;
    chk("t5_no_done", done_cnt, 8);
    job_valid = 1'b1; job_len = 4'd1; exp_q.push_back(1);
    step(); job_valid = 1'b0;
    drain("t5_drain");
    chk("t5_dones", done_cnt, 9);

    // 6: watchdog after 8 ungranted REQ cycles
    step();
    job_valid = 1'b1; job_len = 4'd0; exp_q.push_back(0);
    step(); job_valid = 1'b0;
    step();
    repeat (7) step();
    #2;
    chk("t6_starve_7", int'(starve), 0);
    chk("t6_req", int'(req), 1);
    step(); #2;
    chk("t6_starve_8", int'(starve), WD);
    ack = 1'b1; #1;
    chk("t6_beat", int'(beat), 1);
    chk("t6_starve_hold", int'(starve), WD);
    step(); ack = 1'b0; #2;
    chk("t6_starve_clr", int'(starve), 0);
    step(); step(); #2;
    chk("t6_busy", int'(busy), 0);
    chk("t6_dones", done_cnt, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
